// File: rtl/matrix_result_drain.sv
// Latches the engine result vector on done_in and streams it as 32-bit beats, raw16 or quant8.
// First beat appears the cycle after done_in; one beat per cycle while out_ready, held stable otherwise.
module matrix_result_drain #(
   parameter int ELEMS = 64,
   parameter int RES_W = 16
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic                   done_in,
   input  logic [ELEMS*RES_W-1:0] result_in,
   input  logic                   mode,
   input  logic [3:0]             shift,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   overrun,
   input  logic                   overrun_clr
);

   localparam int CNT_W = $clog2(ELEMS/2);

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [ELEMS*RES_W-1:0] buf_q, buf_d;
   logic                   mode_q, mode_d;
   logic [3:0]             shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [31:0]            out_data_q, out_data_d;
   logic                   out_last_q, out_last_d;
   logic                   overrun_q, overrun_d;

   logic             xfer, at_last, capture, drop;
   logic [CNT_W-1:0] last_idx, cnt_nxt;

   function automatic logic [CNT_W-1:0] last_beat(input logic m);
      return m ? CNT_W'(ELEMS/4 - 1) : CNT_W'(ELEMS/2 - 1);
   endfunction

   function automatic logic [31:0] beat_f(input logic [ELEMS*RES_W-1:0] v, input logic m,
                                          input logic [3:0] sh, input logic [CNT_W-1:0] k);
      logic [31:0]      r;
      logic [RES_W-1:0] e;
      logic [RES_W-1:0] y;
      int               idx;
      r   = '0;
      idx = int'(k);
      if (!m) begin
         r = v[idx*32 +: 32];
      end else begin
         for (int b = 0; b < 4; b++) begin
            e = v[(idx*4 + b)*RES_W +: RES_W];
            y = e >> sh;
            // Anything with bits above the low byte saturates to 0xFF.
            r[8*b +: 8] = (y[RES_W-1:8] != '0) ? 8'hFF : y[7:0];
         end
      end
      return r;
   endfunction

   always_comb begin
      last_idx = last_beat(mode_q);
      cnt_nxt  = cnt_q + 1'b1;
      xfer     = (state_q == DRAIN) && out_ready;
      at_last  = xfer && (cnt_q == last_idx);
      capture  = done_in && ((state_q == IDLE) || at_last);
      drop     = done_in && (state_q == DRAIN) && !at_last;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (capture)      state_d = DRAIN;
      else if (at_last) state_d = IDLE;
   end

   always_comb begin
      out_valid = (state_q == DRAIN);
      busy      = (state_q == DRAIN);
      out_data  = out_data_q;
      out_last  = out_last_q;
      overrun   = overrun_q;
   end

   // Beat data is precomputed into a register so out_ready never reaches the outputs combinationally.
   always_comb begin
      buf_d      = buf_q;
      mode_d     = mode_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      if (capture) begin
         buf_d      = result_in;
         mode_d     = mode;
         shift_d    = shift;
         cnt_d      = '0;
         out_data_d = beat_f(result_in, mode, shift, {CNT_W{1'b0}});
         out_last_d = (last_beat(mode) == {CNT_W{1'b0}});
      end else if (at_last) begin
         cnt_d      = '0;
         out_data_d = '0;
         out_last_d = 1'b0;
      end else if (xfer) begin
         cnt_d      = cnt_nxt;
         out_data_d = beat_f(buf_q, mode_q, shift_q, cnt_nxt);
         out_last_d = (cnt_nxt == last_idx);
      end
      overrun_d = drop | (overrun_q & ~overrun_clr);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         buf_q      <= '0;
         mode_q     <= 1'b0;
         shift_q    <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         mode_q     <= mode_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain: raw, quant8, backpressure, overrun, back-to-back, async reset.
module tb_matrix_result_drain;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          done_in;
   logic [1023:0] result_in;
   logic          mode;
   logic [3:0]    shift;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic          out_last;
   logic          busy;
   logic          overrun;
   logic          overrun_clr;

   int checks = 0;
   int errors = 0;

   logic [1023:0] va, vb, vc;

   matrix_result_drain #(.ELEMS(64), .RES_W(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .done_in(done_in), .result_in(result_in),
      .mode(mode), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .overrun(overrun),
      .overrun_clr(overrun_clr)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference beat, built with integer division rather than shifts.
   function automatic logic [31:0] mbeat(input logic [1023:0] v, input logic m,
                                         input logic [3:0] sh, input int k);
      logic [31:0] r;
      int e, y;
      r = '0;
      if (!m) begin
         r = {v[(2*k+1)*16 +: 16], v[(2*k)*16 +: 16]};
      end else begin
         for (int b = 0; b < 4; b++) begin
            e = int'(v[(4*k+b)*16 +: 16]);
            y = e / (1 << sh);
            r[8*b +: 8] = (y > 255) ? 8'hFF : y[7:0];
         end
      end
      return r;
   endfunction

   task automatic start_job(input logic [1023:0] v, input logic m, input logic [3:0] sh);
      result_in = v;
      mode      = m;
      shift     = sh;
      done_in   = 1'b1;
      tick();
      done_in   = 1'b0;
   endtask

   // Drains a job whose beat 0 is already presented; optionally fires done_in at beat inj_k.
   task automatic run_job(input string name, input logic [1023:0] v, input logic m, input logic [3:0] sh,
                          input int inj_k, input logic [1023:0] iv, input logic im,
                          input logic [3:0] ish, input logic iclr);
      int n;
      n = m ? 16 : 32;
      result_in = ~v;
      mode      = ~m;
      shift     = ~sh;
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s_valid_%0d", name, k), out_valid, 1);
         chk($sformatf("%s_busy_%0d", name, k), busy, 1);
         chk($sformatf("%s_data_%0d", name, k), out_data, mbeat(v, m, sh, k));
         chk($sformatf("%s_last_%0d", name, k), out_last, (k == n-1));
         if (k == inj_k) begin
            done_in     = 1'b1;
            result_in   = iv;
            mode        = im;
            shift       = ish;
            overrun_clr = iclr;
         end
         tick();
         done_in     = 1'b0;
         overrun_clr = 1'b0;
      end
   endtask

   initial begin
      logic        prev_v, prev_l;
      logic [31:0] prev_d;
      int          rx, cyc, lowrun;

      for (int j = 0; j < 64; j++) begin
         va[j*16 +: 16] = 16'(j + 16'h0100);
         vb[j*16 +: 16] = 16'(j * 64);
         vc[j*16 +: 16] = 16'((j * 16'h0123 + 16'h0F0F) & 16'hFFFF);
      end

      HRESETn = 1'b0; done_in = 1'b0; result_in = '0; mode = 1'b0; shift = '0;
      out_ready = 1'b1; overrun_clr = 1'b0;
      #3;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      tick();
      HRESETn = 1'b1;
      tick();

      // Raw drain, ready tied high
      start_job(va, 1'b0, 4'd0);
      chk("raw_beat0_lit", out_data, 32'h01010100);
      run_job("raw", va, 1'b0, 4'd0, -1, '0, 1'b0, 4'd0, 1'b0);
      chk("raw_busy_after", busy, 0);
      chk("raw_valid_after", out_valid, 0);
      chk("raw_beat31_lit", mbeat(va, 1'b0, 4'd0, 31), 32'h013F013E);

      // Quant8 with saturation
      start_job(vb, 1'b1, 4'd2);
      chk("q8_beat0_lit", out_data, 32'h30201000);
      run_job("q8", vb, 1'b1, 4'd2, -1, '0, 1'b0, 4'd0, 1'b0);
      chk("q8_busy_after", busy, 0);
      chk("q8_beat15_lit", mbeat(vb, 1'b1, 4'd2, 15), 32'hFFFFFFFF);

      // Backpressure
      out_ready = 1'b0;
      start_job(vc, 1'b0, 4'd0);
      chk("bp_valid_start", out_valid, 1);
      rx = 0; cyc = 0; lowrun = 0;
      while (rx < 32 && cyc < 2000) begin
         if (lowrun >= 5 || $urandom_range(0, 2) == 0) begin
            out_ready = 1'b1;
            lowrun    = 0;
         end else begin
            out_ready = 1'b0;
            lowrun++;
         end
         prev_v = out_valid;
         prev_d = out_data;
         prev_l = out_last;
         tick();
         cyc++;
         if (prev_v && out_ready) begin
            chk($sformatf("bp_data_%0d", rx), prev_d, mbeat(vc, 1'b0, 4'd0, rx));
            chk($sformatf("bp_last_%0d", rx), prev_l, (rx == 31));
            rx++;
         end else begin
            chk($sformatf("bp_stall_valid_%0d", cyc), out_valid, 1);
            chk($sformatf("bp_stall_data_%0d", cyc), out_data, prev_d);
         end
      end
      chk("bp_count", rx, 32);
      out_ready = 1'b1;
      chk("bp_busy_after", busy, 0);

      // Overrun: dropped done_in at beat 10
      start_job(va, 1'b0, 4'd0);
      run_job("ovr", va, 1'b0, 4'd0, 10, vb, 1'b1, 4'd3, 1'b0);
      chk("ovr_busy_after", busy, 0);
      chk("ovr_flag", overrun, 1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("ovr_cleared", overrun, 0);
      start_job(vc, 1'b0, 4'd0);
      run_job("ovr_sc", vc, 1'b0, 4'd0, 3, va, 1'b1, 4'd2, 1'b1);
      chk("ovr_set_wins", overrun, 1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("ovr_cleared2", overrun, 0);

      // Back-to-back: new done_in on the last-beat transfer
      start_job(va, 1'b0, 4'd0);
      run_job("b2b1", va, 1'b0, 4'd0, 31, vc, 1'b1, 4'd4, 1'b0);
      chk("b2b_busy", busy, 1);
      chk("b2b_overrun", overrun, 0);
      run_job("b2b2", vc, 1'b1, 4'd4, -1, '0, 1'b0, 4'd0, 1'b0);
      chk("b2b_busy_after", busy, 0);
      chk("b2b_overrun_after", overrun, 0);

      // Async reset at beat 5 with overrun set
      start_job(vb, 1'b0, 4'd0);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) done_in = 1'b1;
         tick();
         done_in = 1'b0;
      end
      chk("ar_overrun_pre", overrun, 1);
      chk("ar_beat5", out_data, mbeat(vb, 1'b0, 4'd0, 5));
      HRESETn = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_overrun", overrun, 0);
      chk("ar_data", out_data, 0);
      tick();
      HRESETn = 1'b1;
      tick();
      tick();
      chk("ar_valid_post", out_valid, 0);
      chk("ar_busy_post", busy, 0);
      start_job(va, 1'b0, 4'd0);
      run_job("ar_job", va, 1'b0, 4'd0, -1, '0, 1'b0, 4'd0, 1'b0);
      chk("ar_job_busy_after", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_result_drain.md
Name: matrix_result_drain

Overview:
Downstream stage of the 8x8 matrix multiply engine. Latches the engine's 64 x 16-bit result vector on its one-cycle done pulse and streams it out as 32-bit words over a valid/ready interface, either raw (two 16-bit results per word) or requantized (shift-right and saturate to 8 bits, four results per word). Lets the engine start its next job while the previous result drains to the bus side or to a DMA/FIFO.

Parameters:
ELEMS, 64, number of 16-bit result elements per job; multiple of 4.
RES_W, 16, result element width; fixed at 16 for this revision.

Ports:
HCLK  input  1  clock, rising edge.
HRESETn  input  1  asynchronous active-low reset.
done_in  input  1  one-cycle pulse from the engine; result_in is valid on that cycle.
result_in  input  ELEMS*RES_W  result vector; element j at bits [16j+15:16j].
mode  input  1  0 = raw16, 1 = quant8; sampled with done_in.
shift  input  4  right-shift amount for quant8; sampled with done_in.
out_valid  output  1  out_data holds a valid beat.
out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
out_data  output  32  output beat.
out_last  output  1  high with the final beat of a job.
busy  output  1  high while a job is held or draining.
overrun  output  1  sticky flag: a done_in arrived while busy and was dropped.
overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (async, HRESETn low): state IDLE; out_valid=0, out_data=0, out_last=0, busy=0, overrun=0; beat counter=0; capture buffer cleared. Reset mid-drain aborts the job; no partial beats follow.
- States: IDLE, DRAIN.
- IDLE: on done_in=1, capture result_in, mode and shift into internal registers, beat counter=0, go to DRAIN. busy and out_valid rise in the next cycle.
- DRAIN: out_valid=1, busy=1. out_data/out_last are registered and held stable while out_valid && !out_ready.
- Handshake: a beat transfers on a rising edge with out_valid && out_ready. The counter increments and the next beat is presented in the following cycle, so back-to-back transfers run one beat per cycle.
- Beat count: raw16 = ELEMS/2 (32); quant8 = ELEMS/4 (16). out_last=1 only on beat count-1.
- raw16 beat k: out_data[15:0] = elem[2k], out_data[31:16] = elem[2k+1].
- quant8 beat k: byte b (bits [8b+7:8b]) = q(elem[4k+b]), b=0..3.
- q(x): x is unsigned, y = x >> shift, result = (y > 255) ? 255 : y[7:0]. shift=0 allowed; shift 8..15 are legal.
- After the last beat transfers: go to IDLE, out_valid=0, out_last=0, busy=0 in the next cycle, unless done_in is also high on that edge.
- done_in on the same edge as the last-beat transfer: capture the new job and stay in DRAIN. Beat 0 of the new job is presented in the next cycle. This is not an overrun.
- done_in in DRAIN at any other time: ignored; capture buffer, mode and shift are unchanged; overrun=1 in the next cycle.
- overrun clears only via overrun_clr=1. If a set and a clear occur on the same edge, the set wins.
- mode and shift changes during DRAIN have no effect on the current job.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Raw drain, out_ready tied 1: elem[j]=j+0x100, mode=0. Expect 32 consecutive beats; beat 0 = 0x01010100, beat 31 = 0x013F013E with out_last; busy drops in the cycle after beat 31.
- Quant8 saturate: elem[j]=j*64, mode=1, shift=2. Expect 16 beats; beat 0 = 0x30201000; elements with j*16 > 255 (j>=16) give byte 0xFF; beat 15 = 0xFFFFFFFF with out_last.
- Backpressure: raw job, out_ready toggled pseudo-randomly (hold low up to 5 cycles). out_data stays stable while stalled; the received stream matches the reference model exactly and contains 32 beats.
- Overrun: second done_in at beat 10 of a raw job. Job 1 completes unchanged and overrun=1. Then overrun_clr pulse gives overrun=0; a coincident set and clear leaves overrun=1.
- Back-to-back: second done_in on the same edge as the job-1 last-beat transfer. Job-2 beat 0 follows in the next cycle, busy never drops, overrun stays 0.
- Async reset at beat 5: out_valid, busy and overrun go to 0 immediately. After release, a new done_in drains a full job from beat 0.
